// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter
//   Arbitrates one shared RAM port between instruction fetch (IF) and
//   load/store (LS) requesters. LS wins a simultaneous decision unless IF has
//   been passed over for two LS grants in a row. Misaligned LS accesses are
//   answered with align_err without touching RAM. Every output is decoded
//   from registered state, so there is no combinational path from the
//   request inputs to the RAM strobe.
//
//   Optional feature: define MEM_ACCESS_TIMEOUT_EN to abort a WAIT that lasts
//   TIMEOUT_CYCLES cycles without MFC (timeout_err plus the requester's done).
//   With the macro undefined, WAIT waits for MFC indefinitely and
//   timeout_err is tied low.
//
// Ports
//   Clk, RESET          clock (rising edge), async active-high reset
//   if_req, if_addr     fetch request (level) and address
//   ls_req, ls_we,
//   ls_size, ls_addr    load/store request (level), store flag, size, address
//   MFC                 memory function complete, sampled only in WAIT
//   RAM_enable          RAM access strobe (ISSUE and WAIT)
//   RAM_OpCode          {write, size[1:0], 3'b000}
//   ram_addr            latched access address
//   grant               01 fetch, 10 load/store, 00 none
//   if_done, ls_done    one-cycle completion pulses
//   align_err           pulse with ls_done for a misaligned access
//   timeout_err         pulse with the done of an aborted access
//   busy                high outside IDLE
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no access; arbitration decision taken every cycle
// ISSUE | first RAM cycle, strobe raised with latched address/opcode
// WAIT  | strobe held, waiting for MFC (or timeout)
// DONE  | one-cycle completion pulse for the latched requester
module mem_access_arbiter #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_W         = 32
) (
    input  logic              Clk,
    input  logic              RESET,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [1:0]        ls_size,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic              MFC,
    output logic              RAM_enable,
    output logic [5:0]        RAM_OpCode,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [1:0]        grant,
    output logic              if_done,
    output logic              ls_done,
    output logic              align_err,
    output logic              timeout_err,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] GRANT_IF = 2'b01;
    localparam logic [1:0] GRANT_LS = 2'b10;
    localparam logic [5:0] OP_FETCH = 6'b010000;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t            state, state_nx;
    logic [1:0]        grant_q;
    logic [ADDR_W-1:0] addr_q;
    logic [5:0]        opcode_q;
    logic [1:0]        ls_streak;
    logic              align_q;
    logic              take_if, take_ls;
    logic              ls_misaligned;
    logic              starve_if;
    logic              tmo_hit;
    logic              tmo_expired;

    always_comb begin
        ls_misaligned = 1'b0;
        case (ls_size)
            2'b00:   ls_misaligned = 1'b0;
            2'b01:   ls_misaligned = ls_addr[0];
            2'b10:   ls_misaligned = |ls_addr[1:0];
            default: ls_misaligned = |ls_addr[2:0];
        endcase
    end

    // IF has watched two LS grants in a row: it takes the next decision.
    assign starve_if = if_req && (ls_streak == 2'd2);

    always_comb begin
        state_nx = state;
        take_if  = 1'b0;
        take_ls  = 1'b0;
        tmo_hit  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ls_req && !starve_if) begin
                    take_ls  = 1'b1;
                    state_nx = ls_misaligned ? ST_DONE : ST_ISSUE;
                end else if (if_req) begin
                    take_if  = 1'b1;
                    state_nx = ST_ISSUE;
                end
            end
            ST_ISSUE: state_nx = ST_WAIT;
            ST_WAIT: begin
                if (MFC) begin
                    state_nx = ST_DONE;
                end else if (tmo_expired) begin
                    state_nx = ST_DONE;
                    tmo_hit  = 1'b1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge RESET) begin
        if (RESET) begin
            state     <= ST_IDLE;
            grant_q   <= 2'b00;
            addr_q    <= '0;
            opcode_q  <= 6'b000000;
            ls_streak <= 2'd0;
            align_q   <= 1'b0;
        end else begin
            state <= state_nx;
            if (take_ls) begin
                grant_q   <= GRANT_LS;
                addr_q    <= ls_addr;
                opcode_q  <= {ls_we, ls_size, 3'b000};
                align_q   <= ls_misaligned;
                // Only grants that actually passed over a waiting IF count.
                ls_streak <= if_req ? 2'(ls_streak + 2'd1) : 2'd0;
            end else if (take_if) begin
                grant_q   <= GRANT_IF;
                addr_q    <= if_addr;
                opcode_q  <= OP_FETCH;
                align_q   <= 1'b0;
                ls_streak <= 2'd0;
            end
        end
    end

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_q;

    // Down-counter loaded in ISSUE so the first WAIT cycle sees
    // TIMEOUT_CYCLES-1; terminal count 0 marks the last WAIT cycle.
    always_ff @(posedge Clk or posedge RESET) begin
        if (RESET) begin
            tmo_cnt <= '0;
            tmo_q   <= 1'b0;
        end else begin
            if (state == ST_ISSUE) begin
                tmo_cnt <= TMO_W'(TIMEOUT_CYCLES - 1);
            end else if (state == ST_WAIT && tmo_cnt != '0) begin
                tmo_cnt <= tmo_cnt - 1'b1;
            end
            if (state_nx == ST_DONE) begin
                tmo_q <= tmo_hit;
            end
        end
    end

    assign tmo_expired = (tmo_cnt == '0);
    assign timeout_err = (state == ST_DONE) && tmo_q;
`else
    assign tmo_expired = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign busy       = (state != ST_IDLE);
    assign RAM_enable = (state == ST_ISSUE) || (state == ST_WAIT);
    assign RAM_OpCode = opcode_q;
    assign ram_addr   = addr_q;
    assign grant      = busy ? grant_q : 2'b00;
    assign if_done    = (state == ST_DONE) && (grant_q == GRANT_IF);
    assign ls_done    = (state == ST_DONE) && (grant_q == GRANT_LS);
    assign align_err  = (state == ST_DONE) && align_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter: fetch latency, LS priority,
// starvation guard, alignment, dropped/late requests, timeout (or endless
// WAIT in the default build) and reset in the middle of an access.
module tb_mem_access_arbiter;

    localparam int ADDR_W = 32;
    localparam int TMO    = 16;

    logic              Clk = 1'b0;
    logic              RESET;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              ls_req;
    logic              ls_we;
    logic [1:0]        ls_size;
    logic [ADDR_W-1:0] ls_addr;
    logic              MFC;
    logic              RAM_enable;
    logic [5:0]        RAM_OpCode;
    logic [ADDR_W-1:0] ram_addr;
    logic [1:0]        grant;
    logic              if_done;
    logic              ls_done;
    logic              align_err;
    logic              timeout_err;
    logic              busy;

    int errors = 0;
    int checks = 0;

    mem_access_arbiter #(.TIMEOUT_CYCLES(TMO), .ADDR_W(ADDR_W)) dut (
        .Clk         (Clk),
        .RESET       (RESET),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .ls_req      (ls_req),
        .ls_we       (ls_we),
        .ls_size     (ls_size),
        .ls_addr     (ls_addr),
        .MFC         (MFC),
        .RAM_enable  (RAM_enable),
        .RAM_OpCode  (RAM_OpCode),
        .ram_addr    (ram_addr),
        .grant       (grant),
        .if_done     (if_done),
        .ls_done     (ls_done),
        .align_err   (align_err),
        .timeout_err (timeout_err),
        .busy        (busy)
    );

    always #5 Clk = ~Clk;

    // Inputs are driven and outputs sampled on the falling edge.
    task automatic step();
        @(negedge Clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {RAM_enable, RAM_OpCode, grant, if_done, ls_done, align_err, timeout_err, busy}
    function automatic logic [12:0] outs();
        return {RAM_enable, RAM_OpCode, grant, if_done, ls_done, align_err, timeout_err, busy};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen_done;
        int waits;
        logic [1:0] exp_grant [6];
        exp_grant[0] = 2'b10; exp_grant[1] = 2'b10; exp_grant[2] = 2'b01;
        exp_grant[3] = 2'b10; exp_grant[4] = 2'b10; exp_grant[5] = 2'b01;

        RESET = 1'b1; if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_we = 1'b0;
        ls_size = 2'b00; ls_addr = '0; MFC = 1'b0;
        step(); step();
        chk("reset_outs", 64'(outs()), 64'd0);
        chk("reset_addr", 64'(ram_addr), 64'd0);
        RESET = 1'b0;
        step();
        chk("idle_after_reset", 64'(outs()), 64'd0);

        // Fetch at 0x40, MFC two cycles after RAM_enable rises.
        if_req = 1'b1; if_addr = 32'h40;
        step();
        chk("if_issue_en", 64'(RAM_enable), 64'd1);
        chk("if_issue_grant", 64'(grant), 64'h1);
        chk("if_issue_op", 64'(RAM_OpCode), 64'b010000);
        chk("if_issue_addr", 64'(ram_addr), 64'h40);
        step();
        chk("if_wait1", 64'({RAM_enable, if_done}), 64'b10);
        step();
        chk("if_wait2", 64'({RAM_enable, if_done}), 64'b10);
        MFC = 1'b1;
        step();
        chk("if_done_5th_cycle", 64'({if_done, ls_done, RAM_enable}), 64'b100);
        if_req = 1'b0; MFC = 1'b0;
        step();
        chk("if_back_idle", 64'({busy, if_done}), 64'b00);

        // Simultaneous fetch and store word: LS first, then IF in the next IDLE.
        if_req = 1'b1; if_addr = 32'h200;
        ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b10; ls_addr = 32'h100;
        step();
        chk("both_grant_ls", 64'(grant), 64'h2);
        chk("both_ls_op", 64'(RAM_OpCode), 64'b110000);
        chk("both_ls_addr", 64'(ram_addr), 64'h100);
        step();
        MFC = 1'b1;
        step();
        chk("both_ls_done", 64'({ls_done, if_done}), 64'b10);
        ls_req = 1'b0; MFC = 1'b0;
        step();
        chk("both_idle_gap", 64'(busy), 64'd0);
        step();
        chk("both_then_if", 64'(grant), 64'h1);
        chk("both_if_addr", 64'(ram_addr), 64'h200);
        step();
        MFC = 1'b1;
        step();
        chk("both_if_done", 64'(if_done), 64'd1);
        if_req = 1'b0; MFC = 1'b0;
        step();

        // Continuous LS with IF waiting: LS, LS, IF, LS, LS, IF, back to back.
        if_req = 1'b1; if_addr = 32'h0;
        ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b10; ls_addr = 32'h80;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("starve_grant_%0d", i), 64'(grant), 64'(exp_grant[i]));
            MFC = 1'b1;
            step();
            step();
            MFC = 1'b0;
            step();
            chk($sformatf("starve_idle_%0d", i), 64'(busy), 64'd0);
        end
        // Both requests withdrawn before the decision edge: nothing happens.
        if_req = 1'b0; ls_req = 1'b0;
        step();
        chk("dropped_req", 64'({busy, RAM_enable}), 64'b00);

        // Load halfword at 0x103: straight to DONE with align_err.
        ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b01; ls_addr = 32'h103;
        step();
        chk("align_hw", 64'({RAM_enable, ls_done, align_err}), 64'b011);
        ls_req = 1'b0;
        step();
        chk("align_hw_idle", 64'({busy, align_err}), 64'b00);

        // Doubleword at 0x104 is misaligned.
        ls_req = 1'b1; ls_size = 2'b11; ls_addr = 32'h104;
        step();
        chk("align_dw", 64'({RAM_enable, ls_done, align_err}), 64'b011);
        ls_req = 1'b0;
        step();

        // Store byte at 0x103 is fine; request dropped after grant still completes.
        ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b00; ls_addr = 32'h103;
        step();
        chk("sb_issue", 64'({RAM_enable, RAM_OpCode}), 64'b1_100000);
        ls_req = 1'b0;
        step();
        MFC = 1'b1;
        step();
        chk("sb_done_after_drop", 64'({ls_done, align_err}), 64'b10);
        MFC = 1'b0;
        step();

        // Misaligned fetch goes out unchanged.
        if_req = 1'b1; if_addr = 32'h42;
        step();
        chk("if_misaligned_addr", 64'({RAM_enable, ram_addr}), {31'd0, 1'b1, 32'h42});
        if_req = 1'b0;
        step();
        MFC = 1'b1;
        step();
        chk("if_misaligned_done", 64'({if_done, align_err}), 64'b10);
        MFC = 1'b0;
        step();

        // Load word at 0x200, MFC never arrives.
        ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b10; ls_addr = 32'h200;
        step();
        ls_req = 1'b0;
        waits = 0;
        step();
        while (ls_done !== 1'b1 && waits < 40) begin
            waits++;
            step();
        end
`ifdef MEM_ACCESS_TIMEOUT_EN
        chk("tmo_wait_cycles", 64'(waits), 64'(TMO));
        chk("tmo_err", 64'({ls_done, timeout_err, RAM_enable}), 64'b110);
        step();
        chk("tmo_idle", 64'({busy, timeout_err}), 64'b00);
        // Re-enter WAIT for the reset test.
        if_req = 1'b1; if_addr = 32'h40;
        step();
        if_req = 1'b0;
        step();
`else
        chk("no_tmo_waits", 64'(waits), 64'd40);
        chk("no_tmo_busy", 64'({busy, RAM_enable, timeout_err}), 64'b110);
`endif

        // Reset while in WAIT, then a late MFC.
        chk("pre_reset_wait", 64'({busy, RAM_enable}), 64'b11);
        RESET = 1'b1;
        #1;
        chk("reset_async", 64'(outs()), 64'd0);
        step();
        RESET = 1'b0; MFC = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (if_done || ls_done) seen_done++;
        end
        MFC = 1'b0;
        chk("reset_no_done", 64'(seen_done), 64'd0);
        chk("reset_late_mfc_outs", 64'(outs()), 64'd0);
        chk("reset_late_mfc_addr", 64'(ram_addr), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
